// File: rtl/rtc_bus_ctrl.sv
// RTC bus controller: runs one multiplexed address/data access per start.
// Address phase, recovery gap, data phase, then a done pulse.
module rtc_bus_ctrl #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] dir,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP,
    D_SETUP, D_STROBE, D_HOLD, DONE
  } state_t;

  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       rw_q;
  logic [7:0] dir_q, wdata_q;

  logic       accept;
  logic       req_rw;
  logic [7:0] req_dir, req_wd;

  logic       cs_d, rd_d, wr_d, adn_d, oe_d, busy_d, done_d;
  logic [7:0] out_d;

  assign accept  = (state == IDLE) && start;
  assign req_rw  = accept ? rw    : rw_q;
  assign req_dir = accept ? dir   : dir_q;
  assign req_wd  = accept ? wdata : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
    unique case (state)
      IDLE:     if (start) state_d = A_SETUP;
      A_SETUP: begin
        state_d = A_STROBE;
        cnt_d   = PULSE_LD;
      end
      A_STROBE: if (cnt == 8'd0) state_d = A_HOLD;
      A_HOLD: begin
        state_d = GAP;
        cnt_d   = GAP_LD;
      end
      GAP:      if (cnt == 8'd0) state_d = D_SETUP;
      D_SETUP: begin
        state_d = D_STROBE;
        cnt_d   = PULSE_LD;
      end
      D_STROBE: if (cnt == 8'd0) state_d = D_HOLD;
      D_HOLD:   state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output values are decoded from the next state so they register in step.
  always_comb begin
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    adn_d  = 1'b1;
    oe_d   = 1'b0;
    out_d  = 8'h00;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_d  = 1'b0;
        adn_d = 1'b0;
        oe_d  = 1'b1;
        out_d = req_dir;
        wr_d  = (state_d != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_d  = 1'b0;
        oe_d  = req_rw;
        out_d = req_rw ? req_wd : 8'h00;
        if (state_d == D_STROBE) begin
          wr_d = !req_rw;
          rd_d = req_rw;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      ad_n    <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      rw_q    <= 1'b0;
      dir_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      cs_n   <= cs_d;
      rd_n   <= rd_d;
      wr_n   <= wr_d;
      ad_n   <= adn_d;
      ad_oe  <= oe_d;
      ad_out <= out_d;
      busy   <= busy_d;
      done   <= done_d;
      if (accept) begin
        rw_q    <= rw;
        dir_q   <= dir;
        wdata_q <= wdata;
      end
      if (state == D_STROBE && cnt == 8'd0 && !rw_q)
        rdata <= ad_in;
    end
  end

endmodule
